writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 140 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Merges the ALU and load-result channels into a small in-order queue that
// drains into the single Register_File write port. Queued writes are also
// exposed to the read stage through a combinational forwarding search.
//
// Ports:
//   Clock, Reset                      rising-edge clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data         ALU result channel, accepted when alu_ready
//   alu_ready                         ALU result accepted on this edge if alu_valid
//   mem_valid/mem_rd/mem_data         load result channel, accepted when mem_ready
//   mem_ready                         load result accepted on this edge if mem_valid
//   wb_hold                           register-file write port unavailable this cycle
//   rd, WriteData, RegWrite           queue head presented to Register_File
//   rs, rt                            read addresses currently at Register_File
//   fwd_rs_hit/fwd_rs_data            newest queued write to rs (data 0 when no hit)
//   fwd_rt_hit/fwd_rt_data            newest queued write to rt (data 0 when no hit)
//   count                             occupied queue entries
module writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        alu_valid,
    input  logic [1:0]  alu_rd,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [1:0]  mem_rd,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        wb_hold,
    output logic [1:0]  rd,
    output logic [15:0] WriteData,
    output logic        RegWrite,
    input  logic [1:0]  rs,
    input  logic [1:0]  rt,
    output logic        fwd_rs_hit,
    output logic        fwd_rt_hit,
    output logic [15:0] fwd_rs_data,
    output logic [15:0] fwd_rt_data,
    output logic [1:0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] lastIdx = PW'(DEPTH - 1);
    localparam logic [1:0] fullCount = 2'(DEPTH);

    logic [1:0]    rdQ   [DEPTH];
    logic [15:0]   dataQ [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [1:0]    occ;
    logic [1:0]    starve;

    logic          space;
    logic          starved;
    logic          aluFire;
    logic          memFire;
    logic          push;
    logic          pop;
    logic          headValid;
    logic [1:0]    pushRd;
    logic [15:0]   pushData;
    logic [PW-1:0] searchIdx;

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (p == lastIdx) ? '0 : p + PW'(1);
    endfunction

    // Space is judged on current occupancy only, so a full queue never
    // accepts even when the head is leaving on the same edge.
    assign space   = (occ < fullCount);
    assign starved = (starve == 2'd3);

    // mem has priority unless the ALU has been passed over three times.
    assign alu_ready = !Reset && space && (!mem_valid || starved);
    assign mem_ready = !Reset && space && !(alu_valid && starved);

    assign aluFire  = alu_valid && alu_ready;
    assign memFire  = mem_valid && mem_ready;
    assign push     = aluFire || memFire;
    assign pushRd   = memFire ? mem_rd   : alu_rd;
    assign pushData = memFire ? mem_data : alu_data;

    assign headValid = !Reset && (occ != 2'd0);
    assign RegWrite  = headValid && !wb_hold;
    assign pop       = RegWrite;
    assign rd        = headValid ? rdQ[rdPtr]   : 2'b00;
    assign WriteData = headValid ? dataQ[rdPtr] : 16'd0;
    assign count     = occ;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            occ    <= 2'd0;
            starve <= 2'd0;
        end else begin
            if (push) begin
                rdQ[wrPtr]   <= pushRd;
                dataQ[wrPtr] <= pushData;
                wrPtr        <= incPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= incPtr(rdPtr);
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};

            if (aluFire || !alu_valid) begin
                starve <= 2'd0;
            end else if (mem_valid && space && memFire && !starved) begin
                starve <= starve + 2'd1;
            end
        end
    end

    // Walk from oldest to youngest so the last match wins. Only entries
    // already stored are searched; this cycle's incoming write is not.
    always_comb begin
        fwd_rs_hit  = 1'b0;
        fwd_rt_hit  = 1'b0;
        fwd_rs_data = 16'd0;
        fwd_rt_data = 16'd0;
        searchIdx   = rdPtr;
        for (int i = 0; i < DEPTH; i++) begin
            if (!Reset && (2'(i) < occ)) begin
                if (rdQ[searchIdx] == rs) begin
                    fwd_rs_hit  = 1'b1;
                    fwd_rs_data = dataQ[searchIdx];
                end
                if (rdQ[searchIdx] == rt) begin
                    fwd_rt_hit  = 1'b1;
                    fwd_rt_data = dataQ[searchIdx];
                end
            end
            searchIdx = incPtr(searchIdx);
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        alu_valid;
    logic [1:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [1:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        wb_hold;
    logic [1:0]  rd;
    logic [15:0] WriteData;
    logic        RegWrite;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [15:0] fwd_rs_data;
    logic [15:0] fwd_rt_data;
    logic [1:0]  count;

    writeback_arbiter #(.DEPTH(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_hold(wb_hold), .rd(rd), .WriteData(WriteData), .RegWrite(RegWrite),
        .rs(rs), .rt(rt),
        .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
        .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
        .count(count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        rst;
        logic        aV;
        logic [1:0]  aRd;
        logic [15:0] aD;
        logic        mV;
        logic [1:0]  mRd;
        logic [15:0] mD;
        logic        hold;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic        eAR;
        logic        eMR;
        logic        eRW;
        logic [1:0]  eRd;
        logic [15:0] eWd;
        logic [1:0]  eCnt;
        logic        eRsH;
        logic [15:0] eRsD;
        logic        eRtH;
        logic [15:0] eRtD;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    int nCompared = 0;
    int nMismatched = 0;

    function automatic void setV(input int i,
        input logic rst, input logic aV, input logic [1:0] aRd, input logic [15:0] aD,
        input logic mV, input logic [1:0] mRd, input logic [15:0] mD, input logic hold,
        input logic [1:0] vrs, input logic [1:0] vrt,
        input logic eAR, input logic eMR, input logic eRW, input logic [1:0] eRd,
        input logic [15:0] eWd, input logic [1:0] eCnt,
        input logic eRsH, input logic [15:0] eRsD, input logic eRtH, input logic [15:0] eRtD);
        vecs[i].rst = rst;   vecs[i].aV = aV;   vecs[i].aRd = aRd; vecs[i].aD = aD;
        vecs[i].mV = mV;     vecs[i].mRd = mRd; vecs[i].mD = mD;   vecs[i].hold = hold;
        vecs[i].rs = vrs;    vecs[i].rt = vrt;
        vecs[i].eAR = eAR;   vecs[i].eMR = eMR; vecs[i].eRW = eRW; vecs[i].eRd = eRd;
        vecs[i].eWd = eWd;   vecs[i].eCnt = eCnt;
        vecs[i].eRsH = eRsH; vecs[i].eRsD = eRsD; vecs[i].eRtH = eRtH; vecs[i].eRtD = eRtD;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic aV, input logic [1:0] aRd, input logic [15:0] aD,
                         input logic mV, input logic [1:0] mRd, input logic [15:0] mD,
                         input logic hold, input logic [1:0] vrs, input logic [1:0] vrt);
        Reset = rst; alu_valid = aV; alu_rd = aRd; alu_data = aD;
        mem_valid = mV; mem_rd = mRd; mem_data = mD; wb_hold = hold; rs = vrs; rt = vrt;
    endtask

    logic [1:0]  wRd   [4];
    logic [15:0] wData [4];
    int          nWrites;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //      i  rst aV aRd aD      mV mRd mD       hold rs rt  aR mR RW rd wd      cnt rsH rsD     rtH rtD
        setV( 0, 1, 1, 1, 16'd15,  1, 2, 16'd9,    0,   1, 2,  0, 0, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV( 1, 0, 1, 1, 16'd15,  0, 0, 16'd0,    0,   1, 0,  1, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV( 2, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   1, 0,  1, 1, 1, 1, 16'd15,  1,  1, 16'd15,  0, 16'd0);
        setV( 3, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   1, 0,  1, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV( 4, 0, 1, 1, 16'd15,  1, 2, 16'd9,    1,   2, 1,  0, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV( 5, 0, 1, 1, 16'd15,  0, 0, 16'd0,    1,   2, 1,  1, 1, 0, 2, 16'd9,   1,  1, 16'd9,   0, 16'd0);
        setV( 6, 0, 1, 1, 16'd15,  1, 2, 16'd9,    1,   2, 1,  0, 0, 0, 2, 16'd9,   2,  1, 16'd9,   1, 16'd15);
        setV( 7, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   2, 1,  0, 0, 1, 2, 16'd9,   2,  1, 16'd9,   1, 16'd15);
        setV( 8, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   2, 1,  1, 1, 1, 1, 16'd15,  1,  0, 16'd0,   1, 16'd15);
        setV( 9, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   2, 1,  1, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV(10, 0, 0, 0, 16'd0,   1, 2, 16'd9,    1,   2, 1,  0, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV(11, 0, 0, 0, 16'd0,   1, 2, 16'd7,    1,   2, 1,  0, 1, 0, 2, 16'd9,   1,  1, 16'd9,   0, 16'd0);
        setV(12, 0, 0, 0, 16'd0,   0, 0, 16'd0,    1,   2, 1,  0, 0, 0, 2, 16'd9,   2,  1, 16'd7,   0, 16'd0);
        setV(13, 1, 1, 3, 16'd5,   0, 0, 16'd0,    0,   2, 1,  0, 0, 0, 0, 16'd0,   2,  0, 16'd0,   0, 16'd0);
        setV(14, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   2, 1,  1, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV(15, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   2, 1,  1, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV(16, 0, 1, 3, 16'hAAA, 1, 0, 16'hBBB,  0,   0, 3,  0, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);
        setV(17, 0, 1, 3, 16'hAAA, 1, 0, 16'hBBB,  0,   0, 3,  0, 1, 1, 0, 16'hBBB, 1,  1, 16'hBBB, 0, 16'd0);
        setV(18, 0, 1, 3, 16'hAAA, 1, 0, 16'hBBB,  0,   0, 3,  0, 1, 1, 0, 16'hBBB, 1,  1, 16'hBBB, 0, 16'd0);
        setV(19, 0, 1, 3, 16'hAAA, 1, 0, 16'hBBB,  0,   0, 3,  1, 0, 1, 0, 16'hBBB, 1,  1, 16'hBBB, 0, 16'd0);
        setV(20, 0, 1, 3, 16'hAAA, 1, 0, 16'hBBB,  0,   0, 3,  0, 1, 1, 3, 16'hAAA, 1,  0, 16'd0,   1, 16'hAAA);
        setV(21, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   0, 3,  1, 1, 1, 0, 16'hBBB, 1,  1, 16'hBBB, 0, 16'd0);
        setV(22, 0, 0, 0, 16'd0,   0, 0, 16'd0,    0,   0, 3,  1, 1, 0, 0, 16'd0,   0,  0, 16'd0,   0, 16'd0);

        // Initial reset so the queue state is defined before the table starts.
        repeat (2) @(posedge Clock);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge Clock);
            drive(vecs[i].rst, vecs[i].aV, vecs[i].aRd, vecs[i].aD, vecs[i].mV,
                  vecs[i].mRd, vecs[i].mD, vecs[i].hold, vecs[i].rs, vecs[i].rt);
            #1;
            chk("alu_ready",   i, 16'(alu_ready),   16'(vecs[i].eAR));
            chk("mem_ready",   i, 16'(mem_ready),   16'(vecs[i].eMR));
            chk("RegWrite",    i, 16'(RegWrite),    16'(vecs[i].eRW));
            chk("rd",          i, 16'(rd),          16'(vecs[i].eRd));
            chk("WriteData",   i, WriteData,        vecs[i].eWd);
            chk("count",       i, 16'(count),       16'(vecs[i].eCnt));
            chk("fwd_rs_hit",  i, 16'(fwd_rs_hit),  16'(vecs[i].eRsH));
            chk("fwd_rs_data", i, fwd_rs_data,      vecs[i].eRsD);
            chk("fwd_rt_hit",  i, 16'(fwd_rt_hit),  16'(vecs[i].eRtH));
            chk("fwd_rt_data", i, fwd_rt_data,      vecs[i].eRtD);
        end

        // Hold while full with both channels pushing: nothing accepted, then
        // release drains exactly the two queued writes in order.
        @(negedge Clock);
        drive(0, 0, 0, 0, 1, 2, 16'h222, 1, 2, 3);
        #1 chk("seq mem_ready", 100, 16'(mem_ready), 16'd1);
        @(negedge Clock);
        drive(0, 1, 3, 16'h333, 0, 0, 0, 1, 2, 3);
        #1 chk("seq alu_ready", 101, 16'(alu_ready), 16'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            drive(0, 1, 1, 16'h444, 1, 2, 16'h555, 1, 2, 3);
            #1;
            chk("seq full alu_ready", 102 + c, 16'(alu_ready), 16'd0);
            chk("seq full mem_ready", 102 + c, 16'(mem_ready), 16'd0);
            chk("seq full count",     102 + c, 16'(count),     16'd2);
            chk("seq full RegWrite",  102 + c, 16'(RegWrite),  16'd0);
        end
        chk("seq fwd rs", 106, fwd_rs_data, 16'h222);
        chk("seq fwd rt", 106, fwd_rt_data, 16'h333);

        nWrites = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
            #1;
            if (RegWrite === 1'b1) begin
                if (nWrites < 4) begin
                    wRd[nWrites]   = rd;
                    wData[nWrites] = WriteData;
                end
                nWrites++;
            end
        end
        chk("seq drain writes", 110, 16'(nWrites), 16'd2);
        chk("seq drain count",  111, 16'(count),   16'd0);
        if (nWrites >= 2) begin
            chk("seq first rd",    112, 16'(wRd[0]), 16'd2);
            chk("seq first data",  113, wData[0],    16'h222);
            chk("seq second rd",   114, 16'(wRd[1]), 16'd3);
            chk("seq second data", 115, wData[1],    16'h333);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
